// File: rtl/alu_issue.sv
// alu_issue: FIFO-buffered issue stage feeding a combinational ALU and registering its result
// with tag, opcode and a divide-by-zero flag behind a valid/ready handshake.
module alu_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_a,
    input  logic [15:0]                in_b,
    input  logic [2:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [15:0]                alu_a,
    output logic [15:0]                alu_b,
    output logic [2:0]                 alu_op,
    input  logic [31:0]                alu_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [2:0]                 out_op,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_dz,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 35 + TAG_W;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             r_iss_v;
    logic [15:0]      r_a, r_b;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic             w_push, w_pop, w_adv, w_dz;
    assign in_ready   = r_cnt < CW'(DEPTH);
    assign w_push     = in_valid && in_ready;
    assign w_adv      = r_iss_v && (!out_valid || out_ready);
    assign w_pop      = (r_cnt != '0) && (!r_iss_v || w_adv);
    assign w_dz       = (r_op == 3'b011) && (r_b == 16'h0);
    assign fifo_count = r_cnt;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;
    // Storage array carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {in_a, in_b, in_op, in_tag};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_v <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_tag   <= '0;
        end else if (w_pop) begin
            r_iss_v                  <= 1'b1;
            {r_a, r_b, r_op, r_tag}  <= r_mem[r_rp];
        end else if (w_adv) begin
            r_iss_v <= 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
            out_tag   <= '0;
            out_dz    <= 1'b0;
        end else if (w_adv) begin
            out_valid <= 1'b1;
            out_data  <= w_dz ? 32'h0 : alu_out;
            out_op    <= r_op;
            out_tag   <= r_tag;
            out_dz    <= w_dz;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Command-buffering issue stage that sits directly upstream of the 16-bit ALU and registers the ALU's result. It accepts operand/opcode commands over a valid/ready handshake and queues them in a small FIFO. It presents one command at a time to the ALU through a registered issue slot, then captures the 32-bit ALU result with its tag into an output register that has its own valid/ready handshake. It also flags division by zero, which the ALU does not handle.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2
- TAG_W, 4: width of the user tag carried with each command
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command offered
- in_ready  out  1  FIFO can accept a command
- in_a  in  16  operand A
- in_b  in  16  operand B
- in_op  in  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div/mod, 100 or, 101 and, 110 ~A, 111 ~B
- in_tag  in  TAG_W  user tag, returned unchanged
- alu_a  out  16  operand A to ALU, driven from the issue register
- alu_b  out  16  operand B to ALU, driven from the issue register
- alu_op  out  3  opcode to ALU, driven from the issue register
- alu_out  in  32  combinational ALU result for alu_a/alu_b/alu_op
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes the result
- out_data  out  32  captured result
- out_op  out  3  opcode of the result
- out_tag  out  TAG_W  tag of the result
- out_dz  out  1  op 011 with B==0; out_data forced to 0
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- **Stages.** Three storage stages hold commands: the FIFO, the issue register (iss_v plus a/b/op/tag), and the result register (out_valid plus data/op/tag/dz).
- **Push.**
  - Push occurs when in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH), decoded from registered state only.
  - in_ready has no combinational path from out_ready.
- **Advance.** adv_out = iss_v && (!out_valid || out_ready).
  - On adv_out the result register loads alu_out together with the issue-stage op and tag.
  - If the issue op is 011 and the issue B is 0: out_dz=1 and out_data=32'h0.
  - Otherwise out_dz=0 and out_data=alu_out.
- **Issue.** The issue register loads the FIFO head (pop) when fifo_count>0 && (!iss_v || adv_out).
  - If it does not load and adv_out occurs, iss_v clears.
- **Result drain.** out_valid clears on out_ready when no adv_out occurs in the same cycle.
- **Hold behaviour.**
  - alu_a/alu_b/alu_op hold their last issued values while iss_v=0.
  - The result fields hold while out_valid && !out_ready.
- **Simultaneous push and pop.** Allowed at any occupancy below DEPTH; fifo_count is unchanged.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- **Ordering.** Results are returned strictly in command order.
- **Capacity.** Total in flight is DEPTH+2 commands.
- **Opcodes.** All opcodes pass through; the block does not decode them beyond the divide-by-zero check.

## Timing
- **Reset (rst_n low, asynchronous).** Outputs take these values:
  - in_ready=1 once released
  - fifo_count=0
  - out_valid=0
  - out_data=0, out_op=0, out_tag=0, out_dz=0
  - alu_a=0, alu_b=0, alu_op=0
  - iss_v=0; pointers=0
- **Reset mid-operation.** Asserting rst_n mid-operation discards all queued and in-flight commands.
- **Latency.**
  - Command accepted at edge E0 enters the FIFO.
  - It moves to the issue register at E1 (alu_* valid after E1).
  - It is captured in the result register at E2, so out_valid is high after E2.
  - Minimum latency is 2 cycles; there is no FIFO bypass.
- **Throughput.** One result per cycle when in_valid=1 and out_ready=1 continuously.
- **Handshake rules.**
  - out_data/op/tag/dz stay stable while out_valid && !out_ready.
  - out_valid never drops without a handshake except on reset.
- **Full FIFO.** in_ready=0 in the cycle after fifo_count reaches DEPTH. A pop in that cycle raises in_ready in the following cycle.
- **Empty FIFO.** No pop occurs while fifo_count=0; iss_v clears after its result advances.

## Test plan
- **Single add:** after reset, push A=3, B=5, op=000, tag=1 → out_valid rises 2 cycles after accept; out_data=32'h8, out_tag=1, out_dz=0.
- **Streaming:** out_ready=1, push 8 back-to-back add commands (A=i, B=i, tag=i) → results 0,2,…,14 on consecutive cycles with tags in order; in_ready stays 1.
- **Backpressure fill:** out_ready=0, offer 8 commands → exactly DEPTH+2=6 are accepted and in_ready=0 with fifo_count=4. Raise out_ready → all 6 results drain in order and the remaining 2 are accepted.
- **Divide:** A=17, B=5, op=011 → out_data=32'h0003_0002 (ALU packs A/B in [31:16], A%B in [15:0]), out_dz=0. A=9, B=0, op=011 → out_data=0, out_dz=1.
- **Reset mid-stream:** out_ready=0, 3 commands queued, pulse rst_n low between clock edges → out_valid=0 and fifo_count=0 immediately. After release a new command A=1, B=1, op=100 returns out_data=1 with no stale results emerging.
